// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
//
// Pipelined sprite layering engine for the VGA path. It lays NUM_SPRITES sprite
// layers over a background pixel stream. Layer 0 has the highest priority, and
// KEY_COLOR pixels are transparent. Sprite positions are double-buffered and
// committed at frame start. The block also reports per-sprite opaque-overlap
// collision flags once per frame.
//
// Latency from DrawX/DrawY/blank to Red/Green/Blue is ROM_LATENCY+2 cycles.
// Throughput is one pixel per cycle.
//
// Ports:
//   Clk          pixel clock, rising edge
//   Reset        synchronous, active-high reset
//   frame_start  one-cycle pulse on the (0,0) pixel
//   wr_en        write enable for shadow position register wr_idx
//   wr_idx       target sprite (values >= NUM_SPRITES are ignored)
//   wr_x, wr_y   new top-left corner
//   wr_vis       visible flag
//   DrawX/DrawY  current pixel coordinate
//   blank        1 = active video
//   spr_addr     flattened per-sprite ROM addresses (registered)
//   spr_data     flattened per-sprite ROM pixels, valid ROM_LATENCY after addr
//   bg_data      background pixel, same alignment as spr_data
//   Red/Green/Blue composited pixel (registered)
//   collide      bit i = sprite i overlapped another opaque sprite last frame
// -----------------------------------------------------------------------------
module sprite_compositor #(
   parameter int          NUM_SPRITES = 4,
   parameter int          SPR_W       = 16,
   parameter int          SPR_H       = 24,
   parameter int          ADDR_W      = 10,
   parameter int          ROM_LATENCY = 1,
   parameter logic [23:0] KEY_COLOR   = 24'hFF00FF,
   parameter int          IDX_W       = 2
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          frame_start,
   input  logic                          wr_en,
   input  logic [IDX_W-1:0]              wr_idx,
   input  logic [9:0]                    wr_x,
   input  logic [9:0]                    wr_y,
   input  logic                          wr_vis,
   input  logic [9:0]                    DrawX,
   input  logic [9:0]                    DrawY,
   input  logic                          blank,
   output logic [NUM_SPRITES*ADDR_W-1:0] spr_addr,
   input  logic [NUM_SPRITES*24-1:0]     spr_data,
   input  logic [23:0]                   bg_data,
   output logic [7:0]                    Red,
   output logic [7:0]                    Green,
   output logic [7:0]                    Blue,
   output logic [NUM_SPRITES-1:0]        collide
);

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vis;
   } pos_t;

   localparam logic [9:0] SPR_W10 = 10'(SPR_W);
   localparam logic [9:0] SPR_H10 = 10'(SPR_H);
   // Delay of the S1 flags until they meet the ROM data.
   localparam int         DLY     = ROM_LATENCY;

   pos_t shadow_q [NUM_SPRITES];
   pos_t shadow_d [NUM_SPRITES];
   pos_t active_q [NUM_SPRITES];
   pos_t active_d [NUM_SPRITES];

   logic [9:0]                    dx [NUM_SPRITES];
   logic [9:0]                    dy [NUM_SPRITES];
   logic [NUM_SPRITES-1:0]        hit_d;
   logic [NUM_SPRITES*ADDR_W-1:0] addr_d, addr_q;

   // Index 0 is stage S1. Index DLY lines up with spr_data/bg_data.
   logic [NUM_SPRITES-1:0] hit_pipe_q [DLY+1];
   logic [DLY:0]           blank_pipe_q;
   logic [DLY:0]           fs_pipe_q;

   logic [NUM_SPRITES-1:0] opaque, contrib;
   logic [NUM_SPRITES-1:0] accum_d, accum_q, collide_d, collide_q;
   logic [23:0]            pix, rgb_d, rgb_q;

   // Position registers. A write in the frame_start cycle goes straight into
   // the commit through shadow_d.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      for (int i = 0; i < NUM_SPRITES; i++) begin
         shadow_d[i] = shadow_q[i];
         if (wr_en && wr_idx == IDX_W'(i))
            shadow_d[i] = '{x: wr_x, y: wr_y, vis: wr_vis};
         active_d[i] = frame_start ? shadow_d[i] : active_q[i];
      end
   end

   // Hit test and local address. The subtraction wraps modulo 1024, so a sprite
   // that runs off the right or bottom edge reappears at 0.
   always_comb begin
      hit_d  = '0;
      addr_d = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         dx[i]    = DrawX - active_q[i].x;
         dy[i]    = DrawY - active_q[i].y;
         hit_d[i] = active_q[i].vis && (dx[i] < SPR_W10) && (dy[i] < SPR_H10);
         if (hit_d[i])
            addr_d[i*ADDR_W +: ADDR_W] = ADDR_W'(dy[i]) * ADDR_W'(SPR_W) + ADDR_W'(dx[i]);
      end
   end

   // Compositing and collision, aligned with the ROM data.
   always_comb begin
      pix = bg_data;
      for (int i = 0; i < NUM_SPRITES; i++)
         opaque[i] = hit_pipe_q[DLY][i] && (spr_data[i*24 +: 24] != KEY_COLOR);
      // Walk from lowest priority to highest, so layer 0 wins.
      for (int i = NUM_SPRITES - 1; i >= 0; i--)
         if (opaque[i]) pix = spr_data[i*24 +: 24];
      rgb_d   = blank_pipe_q[DLY] ? pix : 24'h0;
      contrib = (blank_pipe_q[DLY] && ($countones(opaque) >= 2)) ? opaque : '0;
      // The delayed frame_start pixel is the first pixel of the new frame. It
      // seeds accum and does not count toward the frame being reported.
      if (fs_pipe_q[DLY]) begin
         accum_d   = contrib;
         collide_d = accum_q;
      end else begin
         accum_d   = accum_q | contrib;
         collide_d = collide_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. Every register
   // then samples pre-edge values, whatever order the statements are in.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         // NOTE: the position arrays are a small flop-based register file, not a
         // RAM. They must come out of reset invisible, so they are cleared here.
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         for (int k = 0; k <= DLY; k++) hit_pipe_q[k] <= '0;
         addr_q       <= '0;
         blank_pipe_q <= '0;
         fs_pipe_q    <= '0;
         rgb_q        <= '0;
         accum_q      <= '0;
         collide_q    <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
         addr_q          <= addr_d;
         hit_pipe_q[0]   <= hit_d;
         blank_pipe_q[0] <= blank;
         fs_pipe_q[0]    <= frame_start;
         for (int k = 1; k <= DLY; k++) begin
            hit_pipe_q[k]   <= hit_pipe_q[k-1];
            blank_pipe_q[k] <= blank_pipe_q[k-1];
            fs_pipe_q[k]    <= fs_pipe_q[k-1];
         end
         rgb_q     <= rgb_d;
         accum_q   <= accum_d;
         collide_q <= collide_d;
      end
   end

   assign spr_addr = addr_q;
   assign Red      = rgb_q[23:16];
   assign Green    = rgb_q[15:8];
   assign Blue     = rgb_q[7:0];
   assign collide  = collide_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// -----------------------------------------------------------------------------
// tb_sprite_compositor
//
// Directed testbench for sprite_compositor with the default parameters
// (ROM_LATENCY=1, so total latency is 3). Behavioural ROMs return
// per-sprite patterns:
//   sprite 0: KEY at address 0, 24'h123456 elsewhere
//   sprite 1: 24'hABCDEF everywhere
//   sprite 2: {8'h22, address}
//   sprite 3: {8'h33, address}
// The background encodes its own coordinate.
// Inputs are driven on the falling edge. Outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_sprite_compositor;

   localparam int N = 4;
   localparam int A = 10;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          frame_start = 1'b0;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_idx = '0;
   logic [9:0]    wr_x = '0, wr_y = '0;
   logic          wr_vis = 1'b0;
   logic [9:0]    DrawX = '0, DrawY = '0;
   logic          blank = 1'b0;
   logic [N*A-1:0]  spr_addr;
   logic [N*24-1:0] spr_data;
   logic [23:0]   bg_data;
   logic [7:0]    Red, Green, Blue;
   logic [N-1:0]  collide;

   int n_tests = 0;
   int n_fail  = 0;

   sprite_compositor dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis),
      .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .spr_addr(spr_addr), .spr_data(spr_data), .bg_data(bg_data),
      .Red(Red), .Green(Green), .Blue(Blue), .collide(collide)
   );

   always #5 Clk = ~Clk;

   function automatic logic [23:0] rom_val(input int i, input logic [9:0] a);
      case (i)
         0:       return (a == 10'd0) ? 24'hFF00FF : 24'h123456;
         1:       return 24'hABCDEF;
         2:       return {8'h22, 6'h0, a};
         default: return {8'h33, 6'h0, a};
      endcase
   endfunction

   function automatic logic [23:0] bg_val(input logic [9:0] x, input logic [9:0] y);
      return {4'h0, x, y};
   endfunction

   // One-cycle ROMs. Background is delayed two cycles from DrawX/DrawY, the
   // same alignment as the sprite ROM data.
   logic [9:0] x_d1, y_d1;
   always @(posedge Clk) begin
      x_d1    <= DrawX;
      y_d1    <= DrawY;
      bg_data <= bg_val(x_d1, y_d1);
      for (int i = 0; i < N; i++)
         spr_data[i*24 +: 24] <= rom_val(i, spr_addr[i*A +: A]);
   end

   task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                     input logic v);
      @(negedge Clk);
      wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_vis = v;
      @(negedge Clk);
      wr_en = 1'b0;
   endtask

   // Frame start, with an optional write in the same cycle. Returns once the
   // collision flags from the closing frame are visible.
   task automatic fstart(input logic w, input logic [1:0] idx, input logic [9:0] x,
                         input logic [9:0] y, input logic v);
      @(negedge Clk);
      frame_start = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
      wr_en = w; wr_idx = idx; wr_x = x; wr_y = y; wr_vis = v;
      @(negedge Clk);
      frame_start = 1'b0; wr_en = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
   endtask

   // Present one pixel, then idle with blank=0. Check spr_addr one cycle later
   // and the colour three cycles later.
   task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic b, input logic [39:0] exp_addr,
                        input logic [23:0] exp_rgb);
      @(negedge Clk);
      DrawX = x; DrawY = y; blank = b; frame_start = 1'b0;
      @(negedge Clk);
      check({tag, "_addr"}, spr_addr, exp_addr);
      blank = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check({tag, "_rgb"}, 40'({Red, Green, Blue}), 40'(exp_rgb));
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge Clk);
      check("rst_addr", spr_addr, 40'd0);
      check("rst_rgb", 40'({Red, Green, Blue}), 40'd0);
      check("rst_collide", 40'(collide), 40'd0);
      Reset = 1'b0;

      // No writes: background only
      fstart(1'b0, 2'd0, 10'd0, 10'd0, 1'b0);
      probe("bg_only", 10'd300, 10'd100, 1'b1, 40'd0, bg_val(10'd300, 10'd100));
      check("bg_collide", 40'(collide), 40'd0);

      // Shadow write alone must not show
      wr(2'd0, 10'd100, 10'd50, 1'b1);
      probe("pre_commit", 10'd103, 10'd52, 1'b1, 40'd0, bg_val(10'd103, 10'd52));
      fstart(1'b0, 2'd0, 10'd0, 10'd0, 1'b0);
      probe("spr0", 10'd103, 10'd52, 1'b1, {30'd0, 10'd35}, 24'h123456);
      wr(2'd0, 10'd500, 10'd50, 1'b1);
      probe("spr0_hold", 10'd103, 10'd52, 1'b1, {30'd0, 10'd35}, 24'h123456);

      // Overlap of sprites 0 and 1 at (200,200)
      wr(2'd0, 10'd200, 10'd200, 1'b1);
      wr(2'd1, 10'd200, 10'd200, 1'b1);
      fstart(1'b0, 2'd0, 10'd0, 10'd0, 1'b0);
      check("coll_none", 40'(collide), 40'd0);
      probe("ovl_key", 10'd200, 10'd200, 1'b1, 40'd0, 24'hABCDEF);
      probe("ovl_pri", 10'd201, 10'd200, 1'b1, {20'd0, 10'd1, 10'd1}, 24'h123456);

      // Separate the sprites for the next frame
      wr(2'd1, 10'd600, 10'd300, 1'b1);
      fstart(1'b0, 2'd0, 10'd0, 10'd0, 1'b0);
      check("coll_set", 40'(collide), 40'h3);
      probe("sep", 10'd201, 10'd200, 1'b1, {30'd0, 10'd1}, 24'h123456);
      check("coll_hold", 40'(collide), 40'h3);

      // Overlap again, but blanked
      wr(2'd1, 10'd200, 10'd200, 1'b1);
      fstart(1'b0, 2'd0, 10'd0, 10'd0, 1'b0);
      check("coll_clr", 40'(collide), 40'd0);
      probe("blanked", 10'd201, 10'd200, 1'b0, {20'd0, 10'd1, 10'd1}, 24'h000000);

      // Wrap-around sprite 2. Sprite 3 is written in the frame_start cycle.
      wr(2'd0, 10'd200, 10'd200, 1'b0);
      wr(2'd1, 10'd200, 10'd200, 1'b0);
      wr(2'd2, 10'd1020, 10'd10, 1'b1);
      fstart(1'b1, 2'd3, 10'd40, 10'd40, 1'b1);
      check("coll_blank", 40'(collide), 40'd0);
      probe("wrap_1023", 10'd1023, 10'd10, 1'b1, {10'd0, 10'd3, 20'd0}, 24'h220003);
      probe("wrap_0", 10'd0, 10'd10, 1'b1, {10'd0, 10'd4, 20'd0}, 24'h220004);
      probe("wrap_12", 10'd12, 10'd10, 1'b1, 40'd0, bg_val(10'd12, 10'd10));
      probe("row_last", 10'd1020, 10'd33, 1'b1, {10'd0, 10'd368, 20'd0}, 24'h220170);
      probe("row_miss", 10'd1020, 10'd34, 1'b1, 40'd0, bg_val(10'd1020, 10'd34));
      probe("wthru", 10'd41, 10'd41, 1'b1, {10'd17, 30'd0}, 24'h330011);

      // Reset mid-line while streaming an opaque pixel
      @(negedge Clk);
      DrawX = 10'd41; DrawY = 10'd41; blank = 1'b1;
      repeat (3) @(negedge Clk);
      check("pre_rst_rgb", 40'({Red, Green, Blue}), 40'h330011);
      Reset = 1'b1;
      @(negedge Clk);
      check("in_rst_rgb", 40'({Red, Green, Blue}), 40'd0);
      Reset = 1'b0;
      @(negedge Clk);
      check("post1_rgb", 40'({Red, Green, Blue}), 40'd0);
      check("post1_addr", spr_addr, 40'd0);
      @(negedge Clk);
      check("post2_rgb", 40'({Red, Green, Blue}), 40'd0);
      @(negedge Clk);
      check("post3_rgb", 40'({Red, Green, Blue}), 40'(bg_val(10'd41, 10'd41)));
      blank = 1'b0;

      // A commit after reset must find the shadow registers cleared too
      fstart(1'b0, 2'd0, 10'd0, 10'd0, 1'b0);
      check("rst_collide2", 40'(collide), 40'd0);
      probe("rst_clr3", 10'd41, 10'd41, 1'b1, 40'd0, bg_val(10'd41, 10'd41));
      probe("rst_clr2", 10'd1023, 10'd10, 1'b1, 40'd0, bg_val(10'd1023, 10'd10));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised, pipelined sprite layering engine for the VGA path. It replaces the fixed two-player/two-bomb mapper. Each frame it:
- composites NUM_SPRITES sprite layers over a background pixel stream, with fixed priority and colour-key transparency;
- double-buffers sprite positions, committing them at frame start;
- reports per-sprite opaque-overlap collision flags to game logic once per frame.

It sits between the VGA controller and DAC outputs, driving external sprite ROMs.

## Interface
- NUM_SPRITES, 4, number of sprite layers (1-8); index 0 is the highest priority.
- SPR_W, 16, sprite width in pixels (1-32).
- SPR_H, 24, sprite height in pixels (1-32).
- ADDR_W, 10, sprite ROM address width; 2^ADDR_W >= SPR_W*SPR_H.
- ROM_LATENCY, 1, cycles from spr_addr to spr_data/bg_data valid (1-3).
- KEY_COLOR, 24'hFF00FF, transparent RGB value.
- IDX_W, 2, index width; IDX_W = max(1, clog2(NUM_SPRITES)).

Ports:
- Clk  in  1  pixel clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse coincident with the DrawX=0, DrawY=0 pixel.
- wr_en  in  1  writes the shadow position register wr_idx.
- wr_idx  in  IDX_W  target sprite; values >= NUM_SPRITES are ignored.
- wr_x, wr_y  in  10 each  new sprite top-left corner.
- wr_vis  in  1  sprite visible flag.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- blank  in  1  1 = active video.
- spr_addr  out  NUM_SPRITES*ADDR_W  flattened; slice i is the sprite-i local address.
- spr_data  in  NUM_SPRITES*24  flattened; slice i is the sprite-i ROM pixel {R,G,B}.
- bg_data  in  24  background pixel, addressed externally with the same alignment as spr_data.
- Red, Green, Blue  out  8 each  composited pixel.
- collide  out  NUM_SPRITES  bit i = sprite i overlapped another opaque sprite during the previous frame.

## Operation

Position registers:
- Per sprite there is a shadow register {x, y, vis} and an active register {x, y, vis}.
- wr_en updates only the shadow register.
- frame_start copies every shadow register to its active register.
- A write in the same cycle as frame_start is included in the commit (write-through).

Hit test, per sprite, using active registers:
- dx = DrawX - x and dy = DrawY - y, computed modulo 1024 (10-bit).
- hit = vis && dx < SPR_W && dy < SPR_H.
- Wrap-around is defined behaviour: a sprite at x=1020 with SPR_W=16 covers DrawX 1020-1023 and DrawX 0-11.

Address generation:
- spr_addr[i] = dy*SPR_W + dx when hit, else 0.
- The address is registered.

Compositing:
- A layer is opaque when it hit and its spr_data != KEY_COLOR.
- Output = the lowest-index opaque layer; otherwise bg_data.
- blank=0 forces the output to 0.
- bg_data is used as-is; the key colour does not apply to it.

Collision:
- On each active pixel (blank=1) with two or more opaque layers, set accum[i] for every opaque layer i.
- At the aligned frame_start, load collide from accum; accum then holds only that pixel's contribution (or zero).
- collide holds its value for the whole following frame.

Reset:
- Clears all shadow and active registers (x=0, y=0, vis=0), accum, collide, spr_addr, the pipeline valid/blank bits, and Red/Green/Blue.

## Timing
- Stage S0 (cycle t): DrawX, DrawY, blank, and frame_start are sampled.
- Stage S1 (t+1): spr_addr is valid. Hit, blank, and frame_start flags are registered.
- ROM data (spr_data, bg_data) is valid at t+1+ROM_LATENCY. The flags are delayed by a shift register to that cycle.
- Red/Green/Blue are registered at t+2+ROM_LATENCY. Total latency L = ROM_LATENCY+2; throughput is one pixel per cycle with no stalls.
- The collision update and commit use the frame_start delayed by L-1, so all pixels of a frame are counted in that frame.
- Position commit uses the undelayed frame_start. Pixels of the previous frame still in flight keep their already-computed hits.
- Reset mid-operation: outputs are 0 from the cycle after Reset is asserted until L cycles after it is released. Pending writes are lost.

## Test plan
- Reset, then frame_start with no writes -> all sprites invisible; output equals bg_data delayed by L (ROM_LATENCY=1, L=3); spr_addr=0; collide=0.
- Write sprite 0 at (100,50) with vis=1, then frame_start -> at DrawX=103, DrawY=52, spr_addr[0]=2*16+3=35; Red/Green/Blue equal the ROM pixel 3 cycles later. A write without frame_start must not move the displayed sprite.
- Sprites 0 and 1 both at (200,200), ROM 0 returning KEY_COLOR at addr 0 and 24'h123456 elsewhere, ROM 1 returning 24'hABCDEF -> pixel (200,200) shows ABCDEF; pixel (201,200) shows 123456.
- Same overlap held for one frame -> after the next frame_start, collide=4'b0011. A frame with the sprites separated -> collide=0 after the following frame_start.
- Sprite at x=1020 -> hit at DrawX=1023 with spr_addr=3, and at DrawX=0 with spr_addr=4; miss at DrawX=12.
- blank=0 over a visible opaque sprite -> output 0 and no collision is counted. Reset asserted mid-line -> output 0 for L cycles after release; shadow and active registers are cleared.
